// File: rtl/operand_fwd_mod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : operand_fwd_mod                                               |
// | Purpose  : Holds the MEM and WB pipeline registers behind an ALU, the    |
// |            architectural carry/overflow flag register, and selects       |
// |            forwarded operands (data plus {V,C}) for the ALU inputs.      |
// |                                                                          |
// | Ports    : clk, rst                  - clock, async active-high reset    |
// |            ex_valid_i, ex_rd_i,                                          |
// |            ex_result_i, ex_C_flag_i,                                     |
// |            ex_V_flag_i, ex_flag_we_i - EX-stage result and write intent  |
// |            stall_i                   - hold MEM, WB and flags            |
// |            flush_i                   - kill the EX-to-MEM capture        |
// |            rs1_i, rs2_i              - decode source register indices    |
// |            rf_rs1_data_i,                                                |
// |            rf_rs2_data_i             - register-file read data           |
// |            alu_srcA_o, alu_srcB_o    - operands {V, C, data[31:0]}       |
// |            wb_valid_o, wb_rd_o,                                          |
// |            wb_data_o                 - register-file write port          |
// |            flag_C_o, flag_V_o        - architectural flag register       |
// |                                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module operand_fwd_mod #(
  parameter int REG_IDX_W   = 4,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 ex_valid_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic [31:0]          ex_result_i,
  input  logic                 ex_C_flag_i,
  input  logic                 ex_V_flag_i,
  input  logic                 ex_flag_we_i,

  input  logic                 stall_i,
  input  logic                 flush_i,

  input  logic [REG_IDX_W-1:0] rs1_i,
  input  logic [REG_IDX_W-1:0] rs2_i,
  input  logic [31:0]          rf_rs1_data_i,
  input  logic [31:0]          rf_rs2_data_i,

  output logic [33:0]          alu_srcA_o,
  output logic [33:0]          alu_srcB_o,

  output logic                 wb_valid_o,
  output logic [REG_IDX_W-1:0] wb_rd_o,
  output logic [31:0]          wb_data_o,

  output logic                 flag_C_o,
  output logic                 flag_V_o
);

  localparam bit c_zero_reg = (ZERO_REG_EN != 0);

  // --------------------------------------------------------------------------
  // Pipeline state
  // --------------------------------------------------------------------------
  logic                 r_mem_valid;
  logic [REG_IDX_W-1:0] r_mem_rd;
  logic [31:0]          r_mem_result;
  logic                 r_mem_c;
  logic                 r_mem_v;
  logic                 r_mem_flag_we;

  logic                 r_wb_valid;
  logic [REG_IDX_W-1:0] r_wb_rd;
  logic [31:0]          r_wb_result;
  logic                 r_wb_c;
  logic                 r_wb_v;
  logic                 r_wb_flag_we;

  logic                 r_flag_c;
  logic                 r_flag_v;

  // Flags retire from MEM, so the WB copies of C/V/flag_we are carried only
  // to keep the retired record complete; nothing downstream consumes them.
  logic                 w_wb_unused;
  assign w_wb_unused = ^{r_wb_c, r_wb_v, r_wb_flag_we};

  // A MEM entry only writes the flags when it is a real instruction.
  logic w_mem_flag_commit;
  assign w_mem_flag_commit = r_mem_valid & r_mem_flag_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_valid   <= 1'b0;
      r_mem_rd      <= '0;
      r_mem_result  <= '0;
      r_mem_c       <= 1'b0;
      r_mem_v       <= 1'b0;
      r_mem_flag_we <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_result   <= '0;
      r_wb_c        <= 1'b0;
      r_wb_v        <= 1'b0;
      r_wb_flag_we  <= 1'b0;
      r_flag_c      <= 1'b0;
      r_flag_v      <= 1'b0;
    end else if (!stall_i) begin
      // Advance: EX -> MEM, MEM -> WB. A flush only suppresses the new MEM
      // entry; the entry already in MEM still retires normally.
      r_mem_valid   <= ex_valid_i & ~flush_i;
      r_mem_rd      <= ex_rd_i;
      r_mem_result  <= ex_result_i;
      r_mem_c       <= ex_C_flag_i;
      r_mem_v       <= ex_V_flag_i;
      r_mem_flag_we <= ex_flag_we_i;

      r_wb_valid    <= r_mem_valid;
      r_wb_rd       <= r_mem_rd;
      r_wb_result   <= r_mem_result;
      r_wb_c        <= r_mem_c;
      r_wb_v        <= r_mem_v;
      r_wb_flag_we  <= r_mem_flag_we;

      if (w_mem_flag_commit) begin
        r_flag_c <= r_mem_c;
        r_flag_v <= r_mem_v;
      end
    end else if (flush_i) begin
      // Stalled but flushed: only the MEM entry is killed, everything else
      // (including WB and the flag register) holds.
      r_mem_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarded flags: the youngest flag writer in flight overrides the
  // architectural flags. Only MEM can hold an uncommitted flag write.
  // --------------------------------------------------------------------------
  logic w_fwd_c;
  logic w_fwd_v;
  assign w_fwd_c = w_mem_flag_commit ? r_mem_c : r_flag_c;
  assign w_fwd_v = w_mem_flag_commit ? r_mem_v : r_flag_v;

  // --------------------------------------------------------------------------
  // Operand data selection, one identical mux per source operand.
  // Priority: zero register, MEM (youngest), WB, register file.
  // --------------------------------------------------------------------------
  logic [REG_IDX_W-1:0] w_src_idx [2];
  logic [31:0]          w_src_rf  [2];

  assign w_src_idx[0] = rs1_i;
  assign w_src_idx[1] = rs2_i;
  assign w_src_rf[0]  = rf_rs1_data_i;
  assign w_src_rf[1]  = rf_rs2_data_i;

  for (genvar g = 0; g < 2; g++) begin : g_operand
    logic        w_is_zero;
    logic        w_hit_mem;
    logic        w_hit_wb;
    logic [31:0] w_data;

    assign w_is_zero = c_zero_reg && (w_src_idx[g] == '0);
    assign w_hit_mem = r_mem_valid && (r_mem_rd == w_src_idx[g]);
    assign w_hit_wb  = r_wb_valid  && (r_wb_rd  == w_src_idx[g]);

    assign w_data = w_is_zero ? 32'd0        :
                    w_hit_mem ? r_mem_result :
                    w_hit_wb  ? r_wb_result  :
                                w_src_rf[g];
  end

  assign alu_srcA_o = {w_fwd_v, w_fwd_c, g_operand[0].w_data};
  assign alu_srcB_o = {w_fwd_v, w_fwd_c, g_operand[1].w_data};

  // --------------------------------------------------------------------------
  // Register-file write port and architectural flags, straight from state.
  // --------------------------------------------------------------------------
  assign wb_valid_o = r_wb_valid;
  assign wb_rd_o    = r_wb_rd;
  assign wb_data_o  = r_wb_result;

  assign flag_C_o   = r_flag_c;
  assign flag_V_o   = r_flag_v;

endmodule
`default_nettype wire

// File: doc/operand_fwd_mod.md
OPERAND_FWD_MOD -- requirements
Module: operand_fwd_mod

Interface
REQ-001 SHALL have parameter REG_IDX_W, default 4, register index width.
REQ-002 SHALL have parameter ZERO_REG_EN, default 1; 1 makes register 0 read as constant zero.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have ports ex_valid_i 1, ex_rd_i REG_IDX_W, ex_result_i 32, ex_C_flag_i 1, ex_V_flag_i 1, ex_flag_we_i 1, all inputs: EX-stage ALU outputs and write intent.
REQ-006 SHALL have inputs stall_i 1 (hold pipeline) and flush_i 1 (kill EX-to-MEM capture).
REQ-007 SHALL have inputs rs1_i, rs2_i REG_IDX_W and rf_rs1_data_i, rf_rs2_data_i 32: decode source indices and register-file read data.
REQ-008 SHALL have outputs alu_srcA_o, alu_srcB_o 34: packed operands {V, C, data[31:0]}, bit 33 = V, bit 32 = C.
REQ-009 SHALL have outputs wb_valid_o 1, wb_rd_o REG_IDX_W, wb_data_o 32: register-file write port.
REQ-010 SHALL have outputs flag_C_o, flag_V_o 1: architectural flag register.

Function
REQ-011 SHALL hold two pipeline registers, MEM and WB, each holding {valid, rd, result, C, V, flag_we}.
REQ-012 SHALL, on an edge with stall_i=0, load MEM from the ex_* inputs and load WB from MEM; EX-to-wb_* latency is exactly 2 cycles.
REQ-013 SHALL, on an edge with stall_i=1, hold MEM, WB and the flag register unchanged.
REQ-014 SHALL, on an edge with flush_i=1, clear MEM.valid regardless of stall_i; flush has priority over both capture and hold of MEM.
REQ-015 SHALL, when flush_i=1 and stall_i=1 together, hold WB; only MEM.valid changes.
REQ-016 SHALL, on an edge with stall_i=0, MEM.valid=1 and MEM.flag_we=1, write MEM.C and MEM.V into the flag register. Flags commit as MEM moves to WB.
REQ-017 SHALL drive the wb_* outputs straight from WB; wb_valid_o=0 SHALL make wb_rd_o and wb_data_o don't-care.
REQ-018 SHALL select each operand's data combinationally, in this priority order:
- (a) ZERO_REG_EN=1 and index==0 -> 0;
- (b) MEM.valid and MEM.rd==index -> MEM.result;
- (c) WB.valid and WB.rd==index -> WB.result;
- (d) otherwise register-file data.
REQ-019 SHALL drive the forwarded flags {V,C} as MEM.{V,C} when MEM.valid and MEM.flag_we, otherwise as the flag register.
REQ-020 SHALL set bits [33:32] of both alu_srcA_o and alu_srcB_o to the forwarded {V,C}.
REQ-021 SHALL allow MEM and WB to target the same rd; MEM wins (youngest producer).
REQ-022 SHALL ignore the ex_* inputs when ex_valid_i=0 (MEM.valid captures 0); a flag write SHALL require valid=1.
REQ-023 SHALL contain no combinational path from the ex_* inputs to any output.

Reset
REQ-024 SHALL, while rst=1, clear MEM and WB (valid, rd, result, C, V, flag_we all 0) and the flag register to 0, independent of clk.
REQ-025 SHALL, during and immediately after reset, drive wb_valid_o=0, flag_C_o=0, flag_V_o=0, and operands equal to {2'b00, rf data or zero}.
REQ-026 SHALL discard in-flight MEM/WB contents on reset asserted mid-operation; no flag commit on the reset edge.

Verification
REQ-027 SHALL cover basic latency: ex_valid=1, rd=3, result=0x0000_00AA at cycle 0, no stall -> cycle 2 shows wb_valid=1, wb_rd=3, wb_data=0xAA.
REQ-028 SHALL cover forward priority: MEM rd=5 holds 0x11, WB rd=5 holds 0x22, rs1=5, rf data 0x33 -> alu_srcA_o[31:0]=0x11. With MEM invalid -> 0x22. With both invalid -> 0x33.
REQ-029 SHALL cover the zero register: rs2=0, MEM rd=0 holds 0xFFFF_FFFF, ZERO_REG_EN=1 -> alu_srcB_o[31:0]=0.
REQ-030 SHALL cover flag forwarding and commit: EX C=1, V=0, flag_we=1 -> next cycle alu_srcA_o[33:32]=2'b01 while flag_C_o=0 still. One cycle later flag_C_o=1.
REQ-031 SHALL cover stall/flush together: MEM valid rd=7, stall=1 and flush=1 on the same edge -> MEM.valid=0, WB unchanged, flags unchanged.
REQ-032 SHALL cover async reset: rst pulsed between edges with MEM and WB valid and flags=2'b11 -> wb_valid_o=0 and flags=0 immediately, without waiting for a clk edge.
